conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  Builds 3x3 stride-1 convolution windows from a raster-order activation stream. Each pixel arrives as
//  cfg_cin_groups beats of 8 channels x 8 bit, channel-group fastest. Sits upstream of the conv MAC
//  array, which consumes one 9-tap window beat per handshake. Applies 1-pixel border padding, so every
//  input frame of HxW pixels yields exactly HxW output pixels (H*W*G beats).
// PARAMETERS
//  WIDTH          64    bits per beat (8 ch x 8 b)
//  MAX_LINE_WORDS 4096  max cfg_width*cfg_cin_groups (row-buffer depth)
//  MAX_GROUPS     128   max cfg_cin_groups (pixel-delay depth)
// PORTS
//  clk            in   1            clock
//  rst_n          in   1            async active-low reset
//  start          in   1            pulse: latch cfg_*, begin frame (ignored unless IDLE)
//  cfg_width      in   10           W pixels per row, legal 2..
//  cfg_height     in   10           H rows, legal 2..
//  cfg_cin_groups in   8            G = Cin/8, legal 1..MAX_GROUPS
//  cfg_pad_value  in   8            pad byte (used only with CWG_ZERO_POINT_EN)
//  cfg_err        out  1            1-cycle pulse: start rejected, illegal cfg
//  s_valid        in   1            input beat valid
//  s_ready        out  1            input beat accepted when s_valid&s_ready
//  s_data         in   WIDTH        input beat
//  m_valid        out  1            window beat valid
//  m_ready        in   1            downstream accept
//  m_window       out  9*WIDTH      taps [row*3+col]; row0=top, col0=left
//  m_last         out  1            with final beat of frame
//  busy           out  1            state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; m_valid, m_last, s_ready, cfg_err, busy = 0; m_window = 0; counters = 0. Memories not cleared.
//  Clock and reset: single clock; reset is asynchronous, active-low (rst_n).
//  FSM: IDLE -start&legal-> RUN; RUN -last input beat taken-> FLUSH; FLUSH -last flush beat-> DRAIN;
//   DRAIN -final m_valid&m_ready-> IDLE. start&illegal (W<2, H<2, G==0, G>MAX_GROUPS,
//   W*G>MAX_LINE_WORDS): cfg_err=1 for 1 cycle, stay IDLE.
//  adv = (RUN&s_valid | FLUSH) & (!m_valid | m_ready). s_ready = RUN & (!m_valid | m_ready).
//  Each adv shifts one beat (s_data in RUN, pad beat in FLUSH) into:
//   row r+1 path, a W*G-deep row delay for row r, and a second W*G-deep delay for row r-1.
//   Each row path is followed by two G-deep pixel delays, giving the col c+1/c/c-1 taps.
//  Input pixel index p_in = row*W + col. Output pixel p_out = p_in - (W+1); window emitted only when p_in >= W+1.
//  FLUSH injects (W+1)*G pad beats so that the last row/column windows complete.
//  Padding mask uses output coords (r,c): top row taps = pad if r==0; bottom row taps if r==H-1;
//   left col taps if c==0; right col taps if c==W-1. Masks apply to whole beats.
//  Output register: m_window/m_valid update on the cycle after adv that produces a window.
//   m_valid is held with stable data until m_ready. No bubbles under continuous s_valid&m_ready.
//  m_last = 1 on beat H*W*G. No combinational path s_valid->m_valid. m_ready->s_ready is combinational.
//  start during busy: ignored. cfg_* are sampled only at accepted start.
//  rst_n low mid-frame: immediate IDLE; partial frame discarded; next frame needs no priming.
// CONFIGURATION
//  CWG_ZERO_POINT_EN defined: pad beat = {8{cfg_pad_value}} (quantized zero point). Same value for
//   masked taps and flush beats.
//  Not defined: pad beat = '0 and the cfg_pad_value port is still present but ignored.
// STRUCTURE
//  Package conv_pkg: CONV_K=3, LANE_BITS=8, LANES=8, window_t (9 x WIDTH packed), cwg_state_e.
//  Sub-module cwg_word_delay: runtime-depth circular delay.
//   Ports: en, depth, din, dout; registered read; pointer wraps at depth-1.
//   Instantiated 2x (depth W*G, distributed/BRAM) and 6x (depth G).
// TESTING
//  1. W=4,H=3,G=1, s_data=pixel idx 1..12, pad 0 -> 12 beats; beat0 taps {0,0,0,0,1,2,0,5,6}; beat11 m_last=1.
//  2. W=3,H=2,G=2, ramp data -> 12 beats; each window beat g pulls group g of all 9 neighbours.
//  3. Case 1 with m_ready toggling 1010 and s_valid random -> identical window sequence; m_window stable while m_valid&!m_ready.
//  4. start with W=1 -> cfg_err pulses 1 cycle, busy stays 0. start with G=200 -> cfg_err pulses.
//  5. rst_n low after 5 input beats of case 1, then rerun case 1 -> output identical to clean run.
//  6. CWG_ZERO_POINT_EN, pad=0x80, case 1 -> beat0 taps 0,1,2,3,6 = 64'h8080808080808080.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, window type and FSM state encoding for the
// convolution window generator.
package conv_pkg;

   localparam int CONV_K    = 3;
   localparam int LANE_BITS = 8;
   localparam int LANES     = 8;
   localparam int TAPS      = CONV_K * CONV_K;
   localparam int BEAT_W    = LANES * LANE_BITS;

   // Nine taps, index row*3+col, row0 = top, col0 = left.
   typedef logic [TAPS-1:0][BEAT_W-1:0] window_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DRAIN = 2'd3
   } cwg_state_e;

endpackage

// File: rtl/cwg_word_delay.sv
// cwg_word_delay: runtime-depth circular delay line. dout is a registered
// look-ahead read, so between advances it already holds the word written
// 'depth' advances before the word currently presented on din.
module cwg_word_delay
#(
   parameter  int WIDTH     = 64,
   parameter  int MAX_DEPTH = 16,
   localparam int AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1,
   localparam int DW        = $clog2(MAX_DEPTH + 1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DW-1:0]    depth,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [MAX_DEPTH];
   logic [AW-1:0]    ptr_reg, ptr_next;
   logic [DW-1:0]    last_idx;

   assign last_idx = depth - DW'(1);
   assign ptr_next = (DW'(ptr_reg) == last_idx) ? '0 : ptr_reg + AW'(1);

   // Storage write; no reset so it maps onto block/distributed RAM.
   always_ff @(posedge clk) begin
      if (en) mem[ptr_reg] <= din;
   end

   // Pointer and look-ahead read; depth 1 bypasses the array since the
   // slot being read is the one being written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
         dout    <= '0;
      end else if (clr) begin
         ptr_reg <= '0;
      end else if (en) begin
         ptr_reg <= ptr_next;
         dout    <= (ptr_next == ptr_reg) ? din : mem[ptr_next];
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: 3x3 stride-1 window generator with 1-pixel border padding.
// Optional build macro CWG_ZERO_POINT_EN: pad beats carry cfg_pad_value in
// every lane instead of zero.
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int WIDTH          = 64,
   parameter int MAX_LINE_WORDS = 4096,
   parameter int MAX_GROUPS     = 128
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [9:0]            cfg_width,
   input  logic [9:0]            cfg_height,
   input  logic [7:0]            cfg_cin_groups,
   input  logic [7:0]            cfg_pad_value,
   output logic                  cfg_err,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [WIDTH-1:0]      s_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [9*WIDTH-1:0]    m_window,
   output logic                  m_last,
   output logic                  busy
);

   localparam int LW_W  = $clog2(MAX_LINE_WORDS + 1);
   localparam int G_W   = $clog2(MAX_GROUPS + 1);
   localparam int CNT_W = 32;

   cwg_state_e                 state_reg, state_next;
   logic [9:0]                 w_reg, h_reg, o_r_reg, o_c_reg;
   logic [7:0]                 g_reg, o_g_reg;
   logic [LW_W-1:0]            line_words_reg;
   logic [CNT_W-1:0]           warm_reg, last_in_reg, last_step_reg, step_reg;
   logic [TAPS-1:0][WIDTH-1:0] win_reg;
   logic                       m_valid_reg, m_last_reg, cfg_err_reg;

   logic [17:0]                line_words_calc;
   logic [CNT_W-1:0]           warm_calc, total_calc;
   logic                       cfg_legal, start_ok, out_free, adv, emit;
   logic [WIDTH-1:0]           pad_beat, x_beat, row_mid, row_top;
   logic [WIDTH-1:0]           row_src [CONV_K];
   logic [WIDTH-1:0]           taps [TAPS];
   logic [WIDTH-1:0]           taps_masked [TAPS];

`ifdef CWG_ZERO_POINT_EN
   logic [7:0] pad_reg;
   // Zero point is captured with the rest of the frame configuration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pad_reg <= '0;
      else if (start_ok) pad_reg <= cfg_pad_value;
   end
   assign pad_beat = {(WIDTH/LANE_BITS){pad_reg}};
`else
   logic unused_pad;
   assign unused_pad = ^cfg_pad_value;
   assign pad_beat   = '0;
`endif

   // Frame geometry derived from the cfg inputs and its legality check.
   always_comb begin
      line_words_calc = 18'(cfg_width) * 18'(cfg_cin_groups);
      warm_calc       = (CNT_W'(cfg_width) + CNT_W'(1)) * CNT_W'(cfg_cin_groups);
      total_calc      = CNT_W'(cfg_height) * CNT_W'(cfg_width) * CNT_W'(cfg_cin_groups);
      cfg_legal       = (cfg_width >= 10'd2) && (cfg_height >= 10'd2) &&
                        (cfg_cin_groups != 8'd0) &&
                        (32'(cfg_cin_groups) <= MAX_GROUPS) &&
                        (32'(line_words_calc) <= MAX_LINE_WORDS);
   end

   assign start_ok = start && (state_reg == ST_IDLE) && cfg_legal;
   assign out_free = !m_valid_reg || m_ready;
   assign adv      = (((state_reg == ST_RUN) && s_valid) || (state_reg == ST_FLUSH)) && out_free;
   assign emit     = adv && (step_reg >= warm_reg);
   assign s_ready  = (state_reg == ST_RUN) && out_free;
   assign busy     = (state_reg != ST_IDLE);
   assign m_valid  = m_valid_reg;
   assign m_last   = m_last_reg;
   assign m_window = win_reg;
   assign cfg_err  = cfg_err_reg;
   assign x_beat   = (state_reg == ST_RUN) ? s_data : pad_beat;

   // Two row delays give the middle and top rows of the window.
   cwg_word_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_LINE_WORDS)) u_line_mid (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(adv),
      .depth(line_words_reg), .din(x_beat), .dout(row_mid));
   cwg_word_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_LINE_WORDS)) u_line_top (
      .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(adv),
      .depth(line_words_reg), .din(row_mid), .dout(row_top));

   assign row_src[0] = row_top;
   assign row_src[1] = row_mid;
   assign row_src[2] = x_beat;

   // Per row, two pixel delays produce the centre and left columns.
   genvar gi;
   generate
      for (gi = 0; gi < CONV_K; gi++) begin : g_row
         logic [WIDTH-1:0] col_mid, col_left;
         cwg_word_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_GROUPS)) u_pix_a (
            .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(adv),
            .depth(G_W'(g_reg)), .din(row_src[gi]), .dout(col_mid));
         cwg_word_delay #(.WIDTH(WIDTH), .MAX_DEPTH(MAX_GROUPS)) u_pix_b (
            .clk(clk), .rst_n(rst_n), .clr(start_ok), .en(adv),
            .depth(G_W'(g_reg)), .din(col_mid), .dout(col_left));
         assign taps[gi*CONV_K + 2] = row_src[gi];
         assign taps[gi*CONV_K + 1] = col_mid;
         assign taps[gi*CONV_K + 0] = col_left;
      end

      // Border taps of the output pixel are replaced by whole pad beats.
      for (gi = 0; gi < TAPS; gi++) begin : g_mask
         localparam int TR = gi / CONV_K;
         localparam int TC = gi % CONV_K;
         logic pad_tap;
         assign pad_tap = ((TR == 0)        && (o_r_reg == 10'd0))          ||
                          ((TR == CONV_K-1) && (o_r_reg == h_reg - 10'd1))  ||
                          ((TC == 0)        && (o_c_reg == 10'd0))          ||
                          ((TC == CONV_K-1) && (o_c_reg == w_reg - 10'd1));
         assign taps_masked[gi] = pad_tap ? pad_beat : taps[gi];
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Next-state: input phase, pad flush, then wait for the last beat to leave.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         ST_IDLE:  if (start_ok)                             state_next = ST_RUN;
         ST_RUN:   if (adv && (step_reg == last_in_reg))     state_next = ST_FLUSH;
         ST_FLUSH: if (adv && (step_reg == last_step_reg))   state_next = ST_DRAIN;
         ST_DRAIN: if (m_valid_reg && m_ready)               state_next = ST_IDLE;
         default:                                            state_next = ST_IDLE;
      endcase
   end

   // Frame configuration and stream position, cleared at each accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_reg <= '0; h_reg <= '0; g_reg <= '0; line_words_reg <= '0;
         warm_reg <= '0; last_in_reg <= '0; last_step_reg <= '0; step_reg <= '0;
         o_r_reg <= '0; o_c_reg <= '0; o_g_reg <= '0;
      end else if (start_ok) begin
         w_reg          <= cfg_width;
         h_reg          <= cfg_height;
         g_reg          <= cfg_cin_groups;
         line_words_reg <= LW_W'(line_words_calc);
         warm_reg       <= warm_calc;
         last_in_reg    <= total_calc - CNT_W'(1);
         last_step_reg  <= total_calc + warm_calc - CNT_W'(1);
         step_reg       <= '0;
         o_r_reg <= '0; o_c_reg <= '0; o_g_reg <= '0;
      end else if (adv) begin
         step_reg <= step_reg + CNT_W'(1);
         if (emit) begin
            if (o_g_reg == g_reg - 8'd1) begin
               o_g_reg <= '0;
               if (o_c_reg == w_reg - 10'd1) begin
                  o_c_reg <= '0;
                  o_r_reg <= o_r_reg + 10'd1;
               end else begin
                  o_c_reg <= o_c_reg + 10'd1;
               end
            end else begin
               o_g_reg <= o_g_reg + 8'd1;
            end
         end
      end
   end

   // Output register: loads on an emitting advance, holds until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
         win_reg     <= '0;
      end else if (emit) begin
         m_valid_reg <= 1'b1;
         m_last_reg  <= (step_reg == last_step_reg);
         for (int i = 0; i < TAPS; i++) win_reg[i] <= taps_masked[i];
      end else if (m_ready) begin
         m_valid_reg <= 1'b0;
         m_last_reg  <= 1'b0;
      end
   end

   // One-cycle rejection pulse for an illegal start while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cfg_err_reg <= 1'b0;
      else        cfg_err_reg <= start && (state_reg == ST_IDLE) && !cfg_legal;
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed and randomized frames checked against a
// neighbourhood model computed from the frame contents.
module tb_conv_window_gen;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [9:0]   cfg_width, cfg_height;
   logic [7:0]   cfg_cin_groups, cfg_pad_value;
   logic         cfg_err;
   logic         s_valid, s_ready;
   logic [63:0]  s_data;
   logic         m_valid, m_ready, m_last, busy;
   logic [575:0] m_window;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [63:0]  frame_q[$];
   logic [575:0] exp_win_q[$];
   bit           exp_last_q[$];
   logic [575:0] first_win;
   logic [575:0] c1_beat0;

   conv_window_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_cin_groups(cfg_cin_groups), .cfg_pad_value(cfg_pad_value),
      .cfg_err(cfg_err), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_window(m_window),
      .m_last(m_last), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] exp_pad(input logic [7:0] p);
`ifdef CWG_ZERO_POINT_EN
      return {8{p}};
`else
      return (p == p) ? 64'h0 : 64'h0;
`endif
   endfunction

   // Expected windows: every tap is the neighbour pixel's group g, or pad
   // when that neighbour lies outside the frame.
   task automatic build_model(input int w, input int h, input int g,
                              input int mode, input logic [7:0] pad);
      logic [63:0]  pb;
      logic [575:0] win;
      int rr, cc;
      pb = exp_pad(pad);
      frame_q.delete(); exp_win_q.delete(); exp_last_q.delete();
      for (int i = 0; i < h*w*g; i++) begin
         case (mode)
            0:       frame_q.push_back(64'(i + 1));
            1:       frame_q.push_back({8{8'(i + 1)}});
            default: frame_q.push_back({$urandom, $urandom});
         endcase
      end
      for (int r = 0; r < h; r++)
         for (int c = 0; c < w; c++)
            for (int gg = 0; gg < g; gg++) begin
               win = '0;
               for (int dr = 0; dr < 3; dr++)
                  for (int dc = 0; dc < 3; dc++) begin
                     rr = r + dr - 1;
                     cc = c + dc - 1;
                     if (rr < 0 || rr >= h || cc < 0 || cc >= w)
                        win[(dr*3+dc)*64 +: 64] = pb;
                     else
                        win[(dr*3+dc)*64 +: 64] = frame_q[(rr*w+cc)*g + gg];
                  end
               exp_win_q.push_back(win);
               exp_last_q.push_back(r == h-1 && c == w-1 && gg == g-1);
            end
   endtask

   // One frame; thr throttles both sides, abort_at >= 0 resets mid-frame.
   task automatic run_frame(input int w, input int h, input int g, input int mode,
                            input bit thr, input int abort_at, input logic [7:0] pad);
      int total, in_idx, out_idx, cyc;
      logic [575:0] held;
      bit hold_chk;
      build_model(w, h, g, mode, pad);
      total = w*h*g;
      @(negedge clk);
      cfg_width = 10'(w); cfg_height = 10'(h); cfg_cin_groups = 8'(g);
      cfg_pad_value = pad; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cfg_pad_value = ~pad;
      in_idx = 0; out_idx = 0; cyc = 0; hold_chk = 1'b0; held = '0;
      while (out_idx < total && cyc < 4000) begin
         if (abort_at >= 0 && in_idx >= abort_at) break;
         if (hold_chk) begin
            chk("hold_valid", 576'(m_valid), 576'(1));
            chk("hold_window", m_window, held);
         end
         s_valid = (in_idx < total) && (!thr || $urandom_range(0, 1) == 1);
         s_data  = s_valid ? frame_q[in_idx] : {$urandom, $urandom};
         m_ready = thr ? (cyc % 2 == 0) : 1'b1;
         start   = (cyc == 7);
         if (cyc == 7) begin
            cfg_width = 10'd9; cfg_height = 10'd9; cfg_cin_groups = 8'd2;
         end
         #1;
         if (m_valid && m_ready) begin
            if (out_idx == 0) first_win = m_window;
            chk($sformatf("win[%0d]", out_idx), m_window, exp_win_q[out_idx]);
            chk($sformatf("last[%0d]", out_idx), 576'(m_last), 576'(exp_last_q[out_idx]));
            out_idx++;
         end
         hold_chk = m_valid && !m_ready;
         held     = m_window;
         if (s_valid && s_ready) in_idx++;
         cyc++;
         @(negedge clk);
      end
      start = 1'b0; s_valid = 1'b0;
      if (abort_at >= 0) begin
         rst_n = 1'b0; m_ready = 1'b0;
         #1;
         chk("abort_m_valid", 576'(m_valid), 576'(0));
         chk("abort_busy", 576'(busy), 576'(0));
         chk("abort_s_ready", 576'(s_ready), 576'(0));
         @(negedge clk);
         rst_n = 1'b1;
      end else begin
         m_ready = 1'b0;
         chk("frame_out_beats", 576'(out_idx), 576'(total));
         chk("frame_in_beats", 576'(in_idx), 576'(total));
         chk("frame_busy_done", 576'(busy), 576'(0));
         chk("frame_m_valid_done", 576'(m_valid), 576'(0));
      end
      $display("frame W=%0d H=%0d G=%0d thr=%0d abort=%0d beats_out=%0d cycles=%0d",
               w, h, g, thr, abort_at, out_idx, cyc);
   endtask

   task automatic try_illegal(input string tag, input int w, input int h, input int g);
      @(negedge clk);
      cfg_width = 10'(w); cfg_height = 10'(h); cfg_cin_groups = 8'(g); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_err_pulse"}, 576'(cfg_err), 576'(1));
      chk({tag, "_busy"}, 576'(busy), 576'(0));
      @(negedge clk);
      chk({tag, "_err_clear"}, 576'(cfg_err), 576'(0));
      chk({tag, "_busy_after"}, 576'(busy), 576'(0));
      $display("illegal start %s W=%0d H=%0d G=%0d", tag, w, h, g);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
      cfg_width = '0; cfg_height = '0; cfg_cin_groups = '0; cfg_pad_value = '0;
      c1_beat0 = '0;
      c1_beat0[4*64 +: 64] = 64'd1;
      c1_beat0[5*64 +: 64] = 64'd2;
      c1_beat0[7*64 +: 64] = 64'd5;
      c1_beat0[8*64 +: 64] = 64'd6;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_m_valid", 576'(m_valid), 576'(0));
      chk("rst_m_last", 576'(m_last), 576'(0));
      chk("rst_s_ready", 576'(s_ready), 576'(0));
      chk("rst_cfg_err", 576'(cfg_err), 576'(0));
      chk("rst_busy", 576'(busy), 576'(0));
      chk("rst_m_window", m_window, '0);
      rst_n = 1'b1;
      $display("reset released");

      // Case 1: pixel index data, free-flowing
      run_frame(4, 3, 1, 0, 1'b0, -1, 8'h00);
      chk("c1_beat0_taps", first_win, c1_beat0);

      // Case 2: two channel groups, ramp data
      run_frame(3, 2, 2, 1, 1'b0, -1, 8'h00);

      // Case 3: case 1 under back-pressure and random input gaps
      run_frame(4, 3, 1, 0, 1'b1, -1, 8'h00);
      chk("c3_beat0_taps", first_win, c1_beat0);

      // Case 4: illegal configurations
      try_illegal("w1", 1, 3, 1);
      try_illegal("g200", 4, 3, 200);
      try_illegal("g0", 4, 3, 0);

      // Case 5: reset after 5 input beats, then a clean rerun
      run_frame(4, 3, 1, 0, 1'b0, 5, 8'h00);
      run_frame(4, 3, 1, 0, 1'b0, -1, 8'h00);
      chk("c5_beat0_taps", first_win, c1_beat0);

      // Case 6: pad value (takes effect only with the zero-point build)
      run_frame(4, 3, 1, 0, 1'b0, -1, 8'h80);

      // Randomized frames
      for (int t = 0; t < 4; t++)
         run_frame($urandom_range(2, 6), $urandom_range(2, 5), $urandom_range(1, 4),
                   2, 1'($urandom_range(0, 1)), -1, 8'($urandom_range(0, 255)));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
